imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the processor's 256×16 instruction memory. It accepts a byte stream over a valid/ready handshake, frames it as address, count, data words and checksum, and drives the memory's write port. While a load is in progress it holds the processor in reset. It sits between the host/debug byte source and the write side of the instruction RAM. The processor's fetch side only ever reads that RAM.

## Interface
Parameters: none. Widths are fixed by the 8-bit address / 16-bit word memory.

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when idle
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  instruction-memory write enable (one-cycle pulse)
- mem_addr  out  8  write address
- mem_wdata  out  16  write data
- cpu_hold  out  1  processor held in reset while high
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of frame
- err  out  1  checksum mismatch on last frame; sticky

## Operation
- Byte handshake: a byte is consumed on a rising edge where in_valid && in_ready.
- in_ready is high only in ADDR, CNT, HI, LO and CSUM. It is combinational from state and does not depend on in_valid.
- Frame order: start address byte, count byte N, then N words sent high byte first, then a checksum byte.
  - N = 0 means 256 words.
- States and transitions:
  - IDLE: start → ADDR and clear err. start in any other state is ignored.
  - ADDR: byte → base address register → CNT.
  - CNT: byte → word counter (0 loads 256) → HI.
  - HI: byte → high-byte register → LO.
  - LO: byte → issue a write of {hi, byte} at the current address. Then increment the address modulo 256 and decrement the counter. Go to HI if words remain, else CSUM.
  - CSUM: byte → compare → IDLE. Pulse done. err is set to 1 if the check fails.
- Checksum:
  - 8-bit running sum, modulo 256, of every frame byte including address, count and checksum.
  - The frame is good iff the final sum is 0x00.
  - The sum is cleared on start.
- Address wraps 0xFF → 0x00 with no error.
- Writes to memory are never rolled back on a checksum error. err only reports the failure.
- busy = cpu_hold = (state != IDLE).

## Timing
- Reset values: mem_we=0, mem_addr=0x00, mem_wdata=0x0000, done=0, err=0, busy=0, cpu_hold=0, in_ready=0. State is IDLE.
- Reset mid-frame: return to IDLE immediately.
  - Writes already issued stay in memory; a partial word is discarded.
  - err is cleared.
- start → in_ready high on the next cycle.
- LO handshake in cycle t:
  - mem_we=1 in cycle t+1, with mem_addr/mem_wdata registered and valid in the same cycle.
  - mem_addr/mem_wdata hold their last values while mem_we=0.
- CSUM handshake in cycle t: done=1 and err updated in cycle t+1. busy/cpu_hold drop in cycle t+1.
- in_valid gaps in any receive state: the state machine waits indefinitely with no timeout.
- Back-to-back frames: start may be asserted in the same cycle done is high. That new frame is accepted.
- Peak throughput is one byte per cycle, so one write every 2 cycles.

## Structure
- Shared processor package holds:
  - the loader state enum (IDLE, ADDR, CNT, HI, LO, CSUM)
  - IMEM_AW=8 and IMEM_DW=16
- Single module. No sub-module is warranted; the checksum accumulator is one 8-bit adder inside the block.
- The instruction RAM is external. This block only drives its write port.

## Test plan
- Basic frame: start, then 0x10, 0x02, 0x12, 0x34, 0xAB, 0xCD, 0x30 → writes (0x10, 0x1234) and (0x11, 0xABCD). done pulses once, err=0, cpu_hold low one cycle after done.
- Bad checksum: same frame with checksum 0x31 → both writes still occur, done pulses, err=1 and stays 1 until the next start.
- Wrap and count-zero: address 0xFF with count 0x00 and 256 words of value i → writes at 0xFF, 0x00, …, 0xFE. There are exactly 256 mem_we pulses, with data = i.
- Backpressure: basic frame with random 0–5 cycle in_valid gaps → same writes and done as the no-gap case. No byte is consumed while in_valid is low.
- Reset mid-load: assert rst_n low after the first word write of a 3-word frame → all outputs return to reset values at once and only one write is observed. A following clean frame loads correctly.
- Ignored start: pulse start during HI → no state or checksum change, and the frame completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions: memory geometry and loader states.
package imem_loader_pkg;

  localparam int IMEM_AW = 8;
  localparam int IMEM_DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CNT,
    HI,
    LO,
    CSUM
  } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream valid/ready handshake feeding the instruction memory loader.
interface imem_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: frames a byte stream into instruction memory writes,
// holding the cpu in reset while a frame is in flight.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  imem_loader_if.slave       s,
  output logic               mem_we,
  output logic [IMEM_AW-1:0] mem_addr,
  output logic [IMEM_DW-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  ld_state_t state;
  ld_state_t nxt;

  logic [IMEM_AW-1:0] addr;
  logic [IMEM_AW:0]   cnt;
  logic [7:0]         hi;
  logic [7:0]         sum;
  logic [7:0]         nsum;
  logic               fire;
  logic               last;

  assign fire = s.in_valid && s.in_ready;
  assign nsum = sum + s.in_data;
  assign last = (cnt == 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = ADDR;
      ADDR:    if (fire)  nxt = CNT;
      CNT:     if (fire)  nxt = HI;
      HI:      if (fire)  nxt = LO;
      LO:      if (fire)  nxt = last ? CSUM : HI;
      CSUM:    if (fire)  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // every non-idle state is a receive state
  always_comb begin
    busy       = (state != IDLE);
    cpu_hold   = busy;
    s.in_ready = busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      cnt       <= '0;
      hi        <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (state == IDLE && start) begin
        sum <= '0;
        err <= 1'b0;
      end
      if (fire) begin
        sum <= nsum;
        unique case (state)
          ADDR: addr <= s.in_data;
          CNT:  cnt  <= (s.in_data == 8'd0) ? 9'd256
                                             : {1'b0, s.in_data};
          HI:   hi   <= s.in_data;
          LO: begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= {hi, s.in_data};
            addr      <= addr + 8'd1;
            cnt       <= cnt - 9'd1;
          end
          CSUM: begin
            done <= 1'b1;
            err  <= (nsum != 8'h00);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames against a
// frame-level reference model, plus reset and back-to-back sequences.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader_if bus ();

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s         (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;
  int ncons  = 0;
  logic [23:0] got[$];

  always @(posedge clk) begin
    if (mem_we) got.push_back({mem_addr, mem_wdata});
    if (done) ndone++;
    if (bus.in_valid && bus.in_ready) ncons++;
  end

  typedef struct {
    logic [7:0] base;
    logic [7:0] cnt;
    int         pat;
    logic       bad;
    int         gap;
    logic       poke;
    logic       chain;
    logic       exp_err;
  } vec_t;

  vec_t tv[9];
  logic started;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    int k;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, gap)) @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL put_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input logic pre);
    int n;
    int nbad;
    logic [7:0]  s;
    logic [7:0]  a;
    logic [15:0] w;
    logic [7:0]  cs;
    logic [23:0] exq[$];
    n = (v.cnt == 8'd0) ? 256 : int'(v.cnt);
    got.delete();
    ndone = 0;
    ncons = 0;
    if (!pre) pulse_start();
    chk("ready_after_start", bus.in_ready, 1);
    chk("hold_in_frame", cpu_hold, 1);
    s = v.base + v.cnt;
    put(v.base, v.gap);
    put(v.cnt, v.gap);
    if (v.poke) begin
      bus.in_valid = 1'b0;
      pulse_start();
      chk("busy_after_poke", busy, 1);
    end
    for (int i = 0; i < n; i++) begin
      if (v.pat == 0) w = (i == 0) ? 16'h1234 : 16'hABCD;
      else if (v.pat == 1) w = i[15:0];
      else w = 16'($urandom);
      a = v.base + i[7:0];
      exq.push_back({a, w});
      s = s + w[15:8] + w[7:0];
      put(w[15:8], v.gap);
      put(w[7:0], v.gap);
      chk("we_after_lo", mem_we, 1);
    end
    cs = 8'h00 - s + {7'd0, v.bad};
    put(cs, v.gap);
    bus.in_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_drop", busy, 0);
    chk("hold_drop", cpu_hold, 0);
    chk("err_value", err, v.exp_err);
    if (v.chain) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("err_after", err, v.chain ? 1'b0 : v.exp_err);
    chk("ndone", ndone, 1);
    chk("bytes_consumed", ncons, 2 * n + 3);
    chk("nwrites", got.size(), exq.size());
    nbad = 0;
    for (int i = 0; i < exq.size() && i < got.size(); i++)
      if (got[i] !== exq[i]) begin
        if (nbad == 0)
          $display("FAIL write_%0d actual=%06h required=%06h",
                   i, got[i], exq[i]);
        nbad++;
      end
    chk("write_seq", nbad, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    tv[0] = '{8'h10, 8'h02, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h10, 8'h02, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
    tv[2] = '{8'hFF, 8'h00, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[3] = '{8'h10, 8'h02, 0, 1'b0, 5, 1'b0, 1'b0, 1'b0};
    tv[4] = '{8'h20, 8'h03, 2, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    tv[5] = '{8'h30, 8'h04, 2, 1'b1, 0, 1'b0, 1'b1, 1'b1};
    tv[6] = '{8'hFD, 8'h05, 2, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    for (int i = 7; i < 9; i++) begin
      tv[i].base    = 8'($urandom);
      tv[i].cnt     = 8'($urandom_range(1, 8));
      tv[i].pat     = 2;
      tv[i].bad     = 1'($urandom);
      tv[i].gap     = $urandom_range(0, 3);
      tv[i].poke    = 1'($urandom);
      tv[i].chain   = 1'b0;
      tv[i].exp_err = tv[i].bad;
    end

    #12;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    started = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_frame(tv[i], started);
      started = tv[i].chain;
      if (!started) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset in the middle of a 3-word frame, after its first write
    got.delete();
    pulse_start();
    put(8'h40, 0);
    put(8'h03, 0);
    put(8'h11, 0);
    put(8'h22, 0);
    bus.in_valid = 1'b0;
    chk("mid_we", mem_we, 1);
    chk("mid_addr", mem_addr, 8'h40);
    put(8'h33, 0);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    chk("mid_writes", got.size(), 1);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(tv[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "timeout");
  end

endmodule
